branch_predictor_2lvl: RTL and testbench

- Parametrised two-level branch predictor for the IF stage; successor to the fixed 256x2 local-history predictor.
- Supports local-history or gshare indexing, configurable history length and counter width.
- Replaces the single-cycle reset loop with a sweep-init FSM, registers the query result (1-cycle latency), and adds saturating performance counters.
- Query comes from fetch; updates come from ROB commit.

---
 rtl/branch_predictor_2lvl_if.sv | 33 +++
 rtl/branch_predictor_2lvl.sv | 161 ++++++++++++++++
 tb/tb_branch_predictor_2lvl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_2lvl_if.sv
// Fetch-query, prediction, ROB-update and status signals of the two-level branch predictor.
// valid/ready: query_valid and upd_ena are one-cycle strobes that are always accepted; pred_valid follows query_valid by one cycle.
interface branch_predictor_2lvl_if #(
    parameter int STAT_BITS = 32
);
    logic                 query_valid;
    logic [31:0]          query_pc;
    logic [31:0]          query_inst;
    logic                 pred_valid;
    logic                 predicted_jump;
    logic [31:0]          predicted_imm;
    logic                 upd_ena;
    logic [31:0]          upd_pc;
    logic                 upd_taken;
    logic                 upd_mispredict;
    logic                 init_busy;
    logic [STAT_BITS-1:0] stat_branches;
    logic [STAT_BITS-1:0] stat_mispred;

    modport master (
        output query_valid, query_pc, query_inst,
        output upd_ena, upd_pc, upd_taken, upd_mispredict,
        input  pred_valid, predicted_jump, predicted_imm,
        input  init_busy, stat_branches, stat_mispred
    );

    modport slave (
        input  query_valid, query_pc, query_inst,
        input  upd_ena, upd_pc, upd_taken, upd_mispredict,
        output pred_valid, predicted_jump, predicted_imm,
        output init_busy, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predictor_2lvl.sv
// Two-level (local history or gshare) branch predictor with sweep-init of its tables,
// registered query result and saturating performance counters. init_busy mirrors the FSM state.
module branch_predictor_2lvl #(
    parameter int IDX_BITS  = 8,
    parameter int HIST_LEN  = 2,
    parameter int CNT_BITS  = 2,
    parameter int MODE      = 0,
    parameter int STAT_BITS = 32
) (
    input  logic clk,
    input  logic rst,
    branch_predictor_2lvl_if.slave bus
);
    localparam int CIDX   = IDX_BITS + HIST_LEN;
    localparam int N_CNT  = 1 << CIDX;
    localparam int N_HIST = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_WEAK = {1'b1, {(CNT_BITS-1){1'b0}}};
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                r_state, w_state_next;
    logic [CIDX-1:0]       r_ptr, w_ptr_next;
    logic                  w_busy;

    logic [CNT_BITS-1:0]   r_cnt  [N_CNT];
    logic [HIST_LEN-1:0]   r_hist [N_HIST];
    logic [HIST_LEN-1:0]   r_ghr;

    logic                  r_pred_valid, r_pred_jump;
    logic [31:0]           r_pred_imm;
    logic [STAT_BITS-1:0]  r_stat_br, r_stat_mp;

    logic [IDX_BITS-1:0]   w_q_hidx, w_u_hidx;
    logic [CIDX-1:0]       w_q_idx, w_u_idx;
    logic [CNT_BITS-1:0]   w_q_cnt, w_u_cnt, w_u_cnt_next;
    logic [HIST_LEN-1:0]   w_u_hist_cur, w_u_hist_next;
    logic [HIST_LEN:0]     w_u_shift;
    logic                  w_upd_do;
    logic [6:0]            w_opcode;
    logic [31:0]           w_jimm, w_bimm, w_imm;
    logic                  w_jump;
    logic                  w_unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_busy       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_busy     = 1'b1;
                w_ptr_next = r_ptr + 1'b1;
                if (r_ptr == '1) w_state_next = ST_RUN;
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    assign w_q_hidx = bus.query_pc[IDX_BITS+1:2];
    assign w_u_hidx = bus.upd_pc[IDX_BITS+1:2];

    // Both indices use the history as it stands before this edge's update.
    always_comb begin
        if (MODE == 0) begin
            w_q_idx      = {w_q_hidx, r_hist[w_q_hidx]};
            w_u_idx      = {w_u_hidx, r_hist[w_u_hidx]};
            w_u_hist_cur = r_hist[w_u_hidx];
        end else begin
            w_q_idx      = bus.query_pc[CIDX+1:2] ^ {{IDX_BITS{1'b0}}, r_ghr};
            w_u_idx      = bus.upd_pc[CIDX+1:2] ^ {{IDX_BITS{1'b0}}, r_ghr};
            w_u_hist_cur = r_ghr;
        end
    end

    assign w_q_cnt       = r_cnt[w_q_idx];
    assign w_u_cnt       = r_cnt[w_u_idx];
    assign w_upd_do      = bus.upd_ena && (r_state == ST_RUN);
    assign w_u_shift     = {w_u_hist_cur, bus.upd_taken};
    assign w_u_hist_next = w_u_shift[HIST_LEN-1:0];

    always_comb begin
        w_u_cnt_next = w_u_cnt;
        if (bus.upd_taken) begin
            if (w_u_cnt != CNT_MAX) w_u_cnt_next = w_u_cnt + 1'b1;
        end else begin
            if (w_u_cnt != '0) w_u_cnt_next = w_u_cnt - 1'b1;
        end
    end

    assign w_opcode = bus.query_inst[6:0];
    assign w_jimm = {{11{bus.query_inst[31]}}, bus.query_inst[31], bus.query_inst[19:12],
                     bus.query_inst[20], bus.query_inst[30:21], 1'b0};
    assign w_bimm = {{19{bus.query_inst[31]}}, bus.query_inst[31], bus.query_inst[7],
                     bus.query_inst[30:25], bus.query_inst[11:8], 1'b0};

    always_comb begin
        w_jump = 1'b0;
        w_imm  = w_bimm;
        if (w_opcode == OP_JAL) begin
            w_jump = 1'b1;
            w_imm  = w_jimm;
        end else if (w_opcode == OP_BR) begin
            w_jump = (r_state == ST_RUN) && w_q_cnt[CNT_BITS-1];
        end
    end

    // Tables carry no reset: the INIT sweep is what clears them.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_cnt[r_ptr]                <= CNT_WEAK;
            r_hist[r_ptr[IDX_BITS-1:0]] <= '0;
        end else if (w_upd_do) begin
            r_cnt[w_u_idx] <= w_u_cnt_next;
            if (MODE == 0) r_hist[w_u_hidx] <= w_u_hist_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_jump  <= 1'b0;
            r_pred_imm   <= '0;
            r_ghr        <= '0;
            r_stat_br    <= '0;
            r_stat_mp    <= '0;
        end else begin
            r_pred_valid <= bus.query_valid;
            if (bus.query_valid) begin
                r_pred_jump <= w_jump;
                r_pred_imm  <= w_imm;
            end
            if (w_upd_do) begin
                if (MODE != 0) r_ghr <= w_u_hist_next;
                if (r_stat_br != '1) r_stat_br <= r_stat_br + 1'b1;
                if (bus.upd_mispredict && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + 1'b1;
            end
        end
    end

    assign bus.pred_valid     = r_pred_valid;
    assign bus.predicted_jump = r_pred_jump;
    assign bus.predicted_imm  = r_pred_imm;
    assign bus.init_busy      = w_busy;
    assign bus.stat_branches  = r_stat_br;
    assign bus.stat_mispred   = r_stat_mp;

    assign w_unused_bits = ^{bus.query_pc, bus.upd_pc};
endmodule

// File: tb/tb_branch_predictor_2lvl.sv
// Scoreboarded bench: a local-history instance (4-bit stats) and a gshare instance driven from one clock,
// checked against a small behavioural model of the counter/history tables.
module tb_branch_predictor_2lvl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_2lvl_if #(.STAT_BITS(4))  bif0 ();
    branch_predictor_2lvl_if #(.STAT_BITS(32)) bif1 ();

    branch_predictor_2lvl #(.IDX_BITS(8), .HIST_LEN(2), .CNT_BITS(2), .MODE(0), .STAT_BITS(4))
        dut_loc (.clk(clk), .rst(rst), .bus(bif0));
    branch_predictor_2lvl #(.IDX_BITS(8), .HIST_LEN(2), .CNT_BITS(2), .MODE(1), .STAT_BITS(32))
        dut_gsh (.clk(clk), .rst(rst), .bus(bif1));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural model of both predictors
    int          m_cnt [2][1024];
    logic [1:0]  m_hist [256];
    logic [1:0]  m_ghr;
    bit          m_run;
    longint      m_br [2];
    longint      m_mp [2];
    logic        m_last_j [2];
    logic [31:0] m_last_imm [2];

    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];

    task automatic m_reset();
        for (int i = 0; i < 1024; i++) begin
            m_cnt[0][i] = 2;
            m_cnt[1][i] = 2;
        end
        for (int i = 0; i < 256; i++) m_hist[i] = 2'b00;
        m_ghr = 2'b00;
        m_run = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_br[d] = 0;
            m_mp[d] = 0;
            m_last_j[d] = 1'b0;
            m_last_imm[d] = 32'h0;
        end
    endtask

    function automatic int m_idx(input int d, input logic [31:0] pc);
        if (d == 0) return int'({22'b0, pc[9:2], m_hist[pc[9:2]]});
        return int'({22'b0, pc[11:2] ^ {8'b0, m_ghr}});
    endfunction

    function automatic longint m_stat_max(input int d);
        return (d == 0) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    task automatic push_exp(input int d, input logic v, input logic j, input logic [31:0] imm);
        logic [33:0] e;
        if (v) begin
            m_last_j[d]   = j;
            m_last_imm[d] = imm;
        end
        e = {v, m_last_j[d], m_last_imm[d]};
        if (d == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic drive_idle();
        bif0.query_valid = 1'b0; bif0.query_pc = '0; bif0.query_inst = '0;
        bif0.upd_ena = 1'b0; bif0.upd_pc = '0; bif0.upd_taken = 1'b0; bif0.upd_mispredict = 1'b0;
        bif1.query_valid = 1'b0; bif1.query_pc = '0; bif1.query_inst = '0;
        bif1.upd_ena = 1'b0; bif1.upd_pc = '0; bif1.upd_taken = 1'b0; bif1.upd_mispredict = 1'b0;
    endtask

    // One cycle of stimulus on instance d (the other instance idles); called and returns at a negedge.
    task automatic step(input int d, input logic qv, input logic [31:0] qpc, input logic [31:0] qinst,
                        input logic [31:0] qimm, input logic ue, input logic [31:0] upc,
                        input logic ut, input logic um);
        logic j;
        int   i;
        drive_idle();
        if (d == 0) begin
            bif0.query_valid = qv; bif0.query_pc = qpc; bif0.query_inst = qinst;
            bif0.upd_ena = ue; bif0.upd_pc = upc; bif0.upd_taken = ut; bif0.upd_mispredict = um;
        end else begin
            bif1.query_valid = qv; bif1.query_pc = qpc; bif1.query_inst = qinst;
            bif1.upd_ena = ue; bif1.upd_pc = upc; bif1.upd_taken = ut; bif1.upd_mispredict = um;
        end
        if (qinst[6:0] == 7'h6F) j = 1'b1;
        else if (qinst[6:0] == 7'h63) j = m_run && (m_cnt[d][m_idx(d, qpc)] >= 2);
        else j = 1'b0;
        push_exp(d, qv, j, qimm);
        push_exp(1 - d, 1'b0, 1'b0, 32'h0);
        if (ue && m_run) begin
            i = m_idx(d, upc);
            if (ut) m_cnt[d][i] = (m_cnt[d][i] == 3) ? 3 : m_cnt[d][i] + 1;
            else m_cnt[d][i] = (m_cnt[d][i] == 0) ? 0 : m_cnt[d][i] - 1;
            if (d == 0) m_hist[upc[9:2]] = {m_hist[upc[9:2]][0], ut};
            else m_ghr = {m_ghr[0], ut};
            if (m_br[d] < m_stat_max(d)) m_br[d] = m_br[d] + 1;
            if (um && (m_mp[d] < m_stat_max(d))) m_mp[d] = m_mp[d] + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Counts busy cycles of both instances; probe adds a few mid-init transactions.
    task automatic wait_init(input bit probe, output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!bif0.init_busy && !bif1.init_busy) break;
            if (bif0.init_busy) n0++;
            if (bif1.init_busy) n1++;
            if (probe && k == 100) step(0, 1'b1, 32'h100, 32'h63, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            else if (probe && k == 200) step(0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b1);
            else if (probe && k == 300) step(1, 1'b1, 32'h0, 32'h0080006F, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
            else idle_step();
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (exp_q0.size() > 0) check_eq("pred_loc", {30'b0, bif0.pred_valid, bif0.predicted_jump, bif0.predicted_imm}, {30'b0, exp_q0.pop_front()});
            if (exp_q1.size() > 0) check_eq("pred_gsh", {30'b0, bif1.pred_valid, bif1.predicted_jump, bif1.predicted_imm}, {30'b0, exp_q1.pop_front()});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] q_pc   [6] = '{32'h100, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] q_inst [6] = '{32'h00000063, 32'h0080006F, 32'h00008067, 32'hFE000EE3, 32'hFFDFF06F, 32'h00100093};
    logic [31:0] q_imm  [6] = '{32'h0, 32'h8, 32'h0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000800};

    initial begin
        int n0, n1;
        logic [31:0] rpc;
        rst = 1'b0;
        drive_idle();
        m_reset();
        @(negedge clk);

        do_reset();
        check_eq("rst_pred_valid", 64'(bif0.pred_valid), 64'd0);
        check_eq("rst_jump", 64'(bif0.predicted_jump), 64'd0);
        check_eq("rst_imm", 64'(bif0.predicted_imm), 64'd0);
        check_eq("rst_stat_br", 64'(bif0.stat_branches), 64'd0);
        check_eq("rst_stat_mp", 64'(bif0.stat_mispred), 64'd0);
        check_eq("rst_busy", 64'(bif0.init_busy), 64'd1);

        wait_init(1'b1, n0, n1);
        m_run = 1'b1;
        check_eq("init_len_loc", 64'(n0), 64'd1024);
        check_eq("init_len_gsh", 64'(n1), 64'd1024);
        check_eq("busy_after_init", 64'(bif0.init_busy), 64'd0);
        check_eq("upd_ignored_in_init", 64'(bif0.stat_branches), 64'd0);

        for (int i = 0; i < 6; i++) step(0, 1'b1, q_pc[i], q_inst[i], q_imm[i], 1'b0, 32'h0, 1'b0, 1'b0);
        idle_step();
        check_eq("valid_drops", 64'(bif0.pred_valid), 64'd0);

        // Local history, pc 0x200: drive the hist=00 counter down, then rebuild with taken.
        for (int i = 0; i < 3; i++) step(0, 1'b1, 32'h200, 32'h63, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0);
        step(0, 1'b1, 32'h200, 32'h63, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("loc_hist00_nt", 64'(bif0.predicted_jump), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 1'b1, 32'h200, 32'h63, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0);
        step(0, 1'b1, 32'h200, 32'h63, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0);
        check_eq("loc_sat_taken", 64'(bif0.predicted_jump), 64'd1);

        // Same-edge query and update on a fresh entry sees the old (weakly taken) counter.
        step(0, 1'b1, 32'h300, 32'h63, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0);
        check_eq("same_edge_old", 64'(bif0.predicted_jump), 64'd1);
        step(0, 1'b1, 32'h300, 32'h63, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("same_edge_after", 64'(bif0.predicted_jump), 64'd0);

        // gshare: weaken entry 0x13 (pc 0x40 with GHR=11), restore GHR=11, then query pc 0x40.
        step(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1000, 1'b1, 1'b0);
        step(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1000, 1'b1, 1'b0);
        step(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1);
        step(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1000, 1'b1, 1'b0);
        step(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1000, 1'b1, 1'b0);
        step(1, 1'b1, 32'h40, 32'h63, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("gshare_idx13", 64'(bif1.predicted_jump), 64'd0);

        for (int i = 0; i < 300; i++) begin
            rpc = 32'h400 + (32'($urandom_range(0, 15)) << 2);
            step(i % 2, 1'b1, 32'h400 + (32'($urandom_range(0, 15)) << 2), 32'h63, 32'h0,
                 1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 17; i++) step(0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h500, 1'b1, 1'b1);
        check_eq("stat_br_sat", 64'(bif0.stat_branches), 64'd15);
        check_eq("stat_mp_sat", 64'(bif0.stat_mispred), 64'd15);
        check_eq("stat_br_gsh", 64'(bif1.stat_branches), 64'(m_br[1]));
        check_eq("stat_mp_gsh", 64'(bif1.stat_mispred), 64'(m_mp[1]));

        // Reset in the middle of the sweep restarts it from the beginning.
        do_reset();
        for (int i = 0; i < 500; i++) idle_step();
        check_eq("mid_init_busy", 64'(bif0.init_busy), 64'd1);
        do_reset();
        check_eq("rerst_stat_br", 64'(bif0.stat_branches), 64'd0);
        check_eq("rerst_stat_mp", 64'(bif1.stat_mispred), 64'd0);
        wait_init(1'b0, n0, n1);
        m_run = 1'b1;
        check_eq("reinit_len_loc", 64'(n0), 64'd1024);
        check_eq("reinit_len_gsh", 64'(n1), 64'd1024);
        step(0, 1'b1, 32'h200, 32'h63, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("reinit_weak_taken", 64'(bif0.predicted_jump), 64'd1);
        idle_step();
        check_eq("queue_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
